// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// builds a 16-bit snapshot of each full scan frame and debounces whole frames.
// A press is reported once as a one-cycle key_valid pulse with its key code.
// key_down stays high until the key has been released for a full debounce run.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV_BITS   = 15,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [3:0] DEB_FRAMES = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_t;

  logic [3:0]               rows_meta;
  logic [3:0]               rows_sync;
  logic [SCAN_DIV_BITS-1:0] dwell;
  logic [1:0]               col_idx;
  logic [15:0]              map;
  logic [15:0]              map_next;
  logic                     sample;
  logic                     frame_end;
  logic [4:0]               bit_count;
  logic [3:0]               bit_idx;
  logic                     frame_none;
  logic                     frame_key;
  state_t                   state;
  logic [3:0]               cand;
  logic [3:0]               cnt;
  logic [3:0]               rel;

  // Two-flop synchronizer for the asynchronous row lines; idle level is all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  assign sample    = &dwell;
  assign frame_end = sample && (col_idx == 2'd3);

  // One column strobe low at a time, selected by the column index.
  assign cols = ~(4'b0001 << col_idx);

  // Snapshot including the column being sampled this cycle, so the frame
  // classification at column 3 sees the complete frame.
  always_comb begin
    map_next = map;
    map_next[{col_idx, 2'b00} +: 4] = ~rows_sync;
  end

  // Count pressed positions in the frame and remember the index of the last one.
  always_comb begin
    bit_count = 5'd0;
    bit_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (map_next[i]) begin
        bit_count = bit_count + 5'd1;
        bit_idx   = 4'(i);
      end
    end
  end

  assign frame_none = (bit_count == 5'd0);
  assign frame_key  = (bit_count == 5'd1);

  // Free-running dwell counter; at each sample point store the column and advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell   <= '0;
      col_idx <= 2'd0;
      map     <= 16'd0;
    end else begin
      dwell <= dwell + 1'b1;
      if (sample) begin
        col_idx <= col_idx + 2'd1;
        map     <= map_next;
      end
    end
  end

  // Frame-level debounce FSM with registered key outputs; acts only at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= 4'd0;
      rel       <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_key) begin
              cand <= bit_idx;
              if (DEB_FRAMES == 4'd1) begin
                state     <= PRESSED;
                cnt       <= 4'd0;
                rel       <= 4'd0;
                key_code  <= bit_idx;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
                cnt   <= 4'd1;
              end
            end
          end
          DEBOUNCE: begin
            if (frame_key && (bit_idx == cand)) begin
              if (cnt + 4'd1 >= DEB_FRAMES) begin
                state     <= PRESSED;
                cnt       <= 4'd0;
                rel       <= 4'd0;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              state <= IDLE;
              cnt   <= 4'd0;
            end
          end
          PRESSED: begin
            if (frame_none) begin
              if (rel + 4'd1 >= DEB_FRAMES) begin
                state    <= IDLE;
                rel      <= 4'd0;
                key_down <= 1'b0;
              end else begin
                rel <= rel + 4'd1;
              end
            end else begin
              rel <= 4'd0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
            rel   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 keypad (a set of held keys) and
// compares the scanner against a frame-level model of press/release debouncing.
module tb_keypad_scanner;

  localparam int DIV_BITS = 2;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * (1 << DIV_BITS);

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] held;
  int          checks;
  int          errors;
  int          pulses;

  // model state
  int          ticks;
  bit          model_ready;
  bit          m_pressed;
  int          m_streak;
  int          m_cand;
  int          m_rel;
  logic        e_valid;
  logic        e_down;
  logic [3:0]  e_code;

  keypad_scanner #(
    .SCAN_DIV_BITS  (DIV_BITS),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad: a row reads low when a held key connects it to the low column.
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!cols[c] && held[c*4+r]) rows[r] = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Frame model: every FRAME cycles the held set is one frame; a single key seen
  // in DEB consecutive frames (a different single key breaks the run) is a press,
  // and DEB consecutive empty frames while pressed are a release.
  always @(posedge clk) begin
    if (reset) begin
      ticks       = 0;
      model_ready = 1'b1;
      m_pressed   = 1'b0;
      m_streak    = 0;
      m_cand      = 0;
      m_rel       = 0;
      e_valid     = 1'b0;
      e_down      = 1'b0;
      e_code      = 4'd0;
    end else begin
      e_valid = 1'b0;
      if (ticks % FRAME == FRAME - 1) begin
        int n;
        int k;
        n = $countones(held);
        k = 0;
        for (int i = 0; i < 16; i++) if (held[i]) k = i;
        if (m_pressed) begin
          if (n == 0) begin
            m_rel++;
            if (m_rel == DEB) begin
              m_pressed = 1'b0;
              m_rel     = 0;
              e_down    = 1'b0;
            end
          end else begin
            m_rel = 0;
          end
        end else if (n == 1) begin
          if (m_streak == 0) begin
            m_cand   = k;
            m_streak = 1;
          end else if (k == m_cand) begin
            m_streak++;
          end else begin
            m_streak = 0;
          end
          if (m_streak == DEB) begin
            m_streak  = 0;
            m_rel     = 0;
            m_pressed = 1'b1;
            e_valid   = 1'b1;
            e_down    = 1'b1;
            e_code    = 4'(m_cand);
          end
        end else begin
          m_streak = 0;
        end
      end
      ticks++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("cols", {12'd0, cols}, {12'd0, ~(4'b0001 << ((ticks / 4) % 4))});
      checkOutput("key_valid", {15'd0, key_valid}, {15'd0, e_valid});
      checkOutput("key_down", {15'd0, key_down}, {15'd0, e_down});
      checkOutput("key_code", {12'd0, key_code}, {12'd0, e_code});
    end
  end

  // Hold a key set for n whole frames, counting key_valid pulses on the way.
  task automatic applyStimulus(input logic [15:0] keys, input int n);
    held = keys;
    repeat (n * FRAME) begin
      @(negedge clk);
      #1;
      if (key_valid === 1'b1) pulses++;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    logic [15:0] pat;
    checks = 0;
    errors = 0;
    pulses = 0;
    held   = 16'd0;
    reset  = 1'b1;
    model_ready = 1'b0;

    // idle scan after reset
    doReset();
    checkOutput("lit_reset_code", {12'd0, key_code}, 16'd0);
    checkOutput("lit_reset_cols", {12'd0, cols}, 16'he);
    applyStimulus(16'd0, 2);
    checkOutput("lit_idle_pulses", 16'(pulses), 16'd0);

    // key 9 held from reset: accepted at end of frame 3
    held = 16'h0200;
    doReset();
    applyStimulus(16'h0200, 2);
    checkOutput("lit_k9_early_down", {15'd0, key_down}, 16'd0);
    applyStimulus(16'h0200, 1);
    checkOutput("lit_k9_valid", {15'd0, key_valid}, 16'd1);
    checkOutput("lit_k9_code", {12'd0, key_code}, 16'd9);
    checkOutput("lit_k9_down", {15'd0, key_down}, 16'd1);
    p0 = pulses;
    applyStimulus(16'h0200, 3);
    checkOutput("lit_k9_no_repeat", 16'(pulses - p0), 16'd0);

    // bounce: 2 frames, gap, then needs 3 fresh frames
    applyStimulus(16'd0, 3);
    checkOutput("lit_release_down", {15'd0, key_down}, 16'd0);
    p0 = pulses;
    applyStimulus(16'h0200, 2);
    applyStimulus(16'd0, 1);
    applyStimulus(16'h0200, 2);
    checkOutput("lit_bounce_nopulse", 16'(pulses - p0), 16'd0);
    applyStimulus(16'h0200, 1);
    checkOutput("lit_bounce_valid", {15'd0, key_valid}, 16'd1);
    applyStimulus(16'd0, 3);

    // ghosting: keys 0 and 5 never accepted
    p0 = pulses;
    applyStimulus(16'h0021, 4);
    checkOutput("lit_multi_nopulse", 16'(pulses - p0), 16'd0);
    checkOutput("lit_multi_down", {15'd0, key_down}, 16'd0);
    applyStimulus(16'h0008, 3);
    checkOutput("lit_k3_code", {12'd0, key_code}, 16'd3);
    p0 = pulses;
    applyStimulus(16'h1008, 3);
    checkOutput("lit_k3k12_down", {15'd0, key_down}, 16'd1);
    checkOutput("lit_k3k12_code", {12'd0, key_code}, 16'd3);
    checkOutput("lit_k3k12_nopulse", 16'(pulses - p0), 16'd0);

    // short release keeps key_down; full release drops it
    applyStimulus(16'd0, 2);
    applyStimulus(16'h0008, 2);
    checkOutput("lit_short_rel_down", {15'd0, key_down}, 16'd1);
    checkOutput("lit_short_rel_nopulse", 16'(pulses - p0), 16'd0);
    applyStimulus(16'd0, 3);
    checkOutput("lit_full_rel_down", {15'd0, key_down}, 16'd0);
    applyStimulus(16'h0008, 3);
    checkOutput("lit_repress_pulses", 16'(pulses - p0), 16'd1);
    applyStimulus(16'd0, 3);

    // reset in the middle of a debounce run
    applyStimulus(16'h0040, 2);
    doReset();
    checkOutput("lit_midreset_down", {15'd0, key_down}, 16'd0);
    applyStimulus(16'h0040, 2);
    checkOutput("lit_midreset_early", {15'd0, key_down}, 16'd0);
    applyStimulus(16'h0040, 1);
    checkOutput("lit_midreset_valid", {15'd0, key_valid}, 16'd1);
    checkOutput("lit_midreset_code", {12'd0, key_code}, 16'd6);

    // randomized key patterns, checked by the model every cycle
    pat = 16'd0;
    for (int it = 0; it < 40; it++) begin
      int r;
      if ($urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 3) pat = 16'd0;
        else if (r < 8) pat = 16'd1 << $urandom_range(0, 15);
        else pat = (16'd1 << $urandom_range(0, 7)) | (16'd1 << $urandom_range(8, 15));
      end
      applyStimulus(pat, int'($urandom_range(1, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
